// File: rtl/prefetch_queue.sv
// Instruction prefetch queue.
// Fetches 16-bit words from cs:fetch_ip into a small byte FIFO that the
// decoder drains one byte at a time. load_new_ip flushes the queue and moves
// the fetch point. A flush that arrives while a read is outstanding parks the
// FSM in ABORT so that the in-flight completion can be absorbed and dropped.
//
// Memory handshake: mem_access is a request level. Once raised it stays high,
// with mem_address stable, until the cycle in which mem_ack strobes for one
// cycle with mem_data valid. mem_access is low in the cycle after mem_ack.
module prefetch_queue #(
  parameter int QUEUE_DEPTH = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_new_ip,
  input  logic [15:0] new_cs,
  input  logic [15:0] new_ip,
  output logic        mem_access,
  input  logic        mem_ack,
  output logic [18:0] mem_address,
  input  logic [15:0] mem_data,
  input  logic        fifo_rd_en,
  output logic [7:0]  fifo_rd_data,
  output logic        fifo_empty,
  output logic [1:0]  debug_state
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [15:0]        cs;
  logic [15:0]        fetch_ip;
  logic [18:0]        addr_q;
  logic [7:0]         q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_ptr_1;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free_slots;
  logic [CNT_W-1:0]   n_wr;
  logic [CNT_W-1:0]   n_pop;
  logic [19:0]        linear;
  logic               can_fetch;
  logic               accept;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign linear     = {cs, 4'h0} + {4'h0, fetch_ip};
  assign free_slots = CNT_W'(QUEUE_DEPTH) - count;
  // An odd fetch point only brings in the upper byte, so one free slot is enough.
  assign can_fetch  = (free_slots >= CNT_W'(2)) ||
                      ((free_slots >= CNT_W'(1)) && fetch_ip[0]);
  // Data is kept only for a live request that is not being flushed this cycle.
  assign accept     = (state == FETCH) && mem_ack && !load_new_ip;
  assign pop        = fifo_rd_en && (count != '0);
  assign wr_ptr_1   = ptr_inc(wr_ptr);
  assign n_wr       = accept ? (fetch_ip[0] ? CNT_W'(1) : CNT_W'(2)) : '0;
  assign n_pop      = pop ? CNT_W'(1) : '0;

  assign mem_access   = (state != IDLE);
  assign mem_address  = addr_q;
  assign fifo_rd_data = q_mem[rd_ptr];
  assign fifo_empty   = (count == '0);
  assign debug_state  = state;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next-state: start a fetch when room exists, absorb stale acks in ABORT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!load_new_ip && can_fetch) state_next = FETCH;
      FETCH:   if (mem_ack)                   state_next = IDLE;
               else if (load_new_ip)          state_next = ABORT;
      ABORT:   if (mem_ack)                   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request address is captured at launch so a flush cannot disturb it.
  always_ff @(posedge clk) begin
    if (!reset_n)                                 addr_q <= '0;
    else if (state == IDLE && state_next == FETCH) addr_q <= linear[19:1];
  end

  // Fetch point: reload on flush, advance by the number of bytes accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs       <= 16'hFFFF;
      fetch_ip <= 16'h0000;
    end else if (load_new_ip) begin
      cs       <= new_cs;
      fetch_ip <= new_ip;
    end else if (accept) begin
      fetch_ip <= fetch_ip + (fetch_ip[0] ? 16'd1 : 16'd2);
    end
  end

  // Byte storage: low byte first for an even address, upper byte only if odd.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (fetch_ip[0]) begin
        q_mem[wr_ptr]   <= mem_data[15:8];
      end else begin
        q_mem[wr_ptr]   <= mem_data[7:0];
        q_mem[wr_ptr_1] <= mem_data[15:8];
      end
    end
  end

  // Pointers and occupancy; a flush empties the queue and overrides pop/write.
  always_ff @(posedge clk) begin
    if (!reset_n || load_new_ip) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      if (accept) wr_ptr <= fetch_ip[0] ? wr_ptr_1 : ptr_inc(wr_ptr_1);
      count <= count + n_wr - n_pop;
    end
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001: Parameter QUEUE_DEPTH, default 6, byte capacity of the instruction byte queue; legal values are 4..8.
REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003: reset_n  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-004: load_new_ip  input  1  flush pulse; new_cs/new_ip become the fetch point.
REQ-005: new_cs  input  16  code segment loaded on load_new_ip.
REQ-006: new_ip  input  16  instruction pointer loaded on load_new_ip.
REQ-007: mem_access  output  1  memory read request, held high until mem_ack.
REQ-008: mem_ack  input  1  one-cycle completion strobe; mem_data valid in the same cycle.
REQ-009: mem_address  output  19  word address [19:1] of the request.
REQ-010: mem_data  input  16  read data; low byte at the even address.
REQ-011: fifo_rd_en  input  1  decoder pops the head byte.
REQ-012: fifo_rd_data  output  8  head byte, valid whenever fifo_empty is low.
REQ-013: fifo_empty  output  1  queue holds zero bytes.

Function
REQ-014: Linear address SHALL be computed as (cs << 4) + fetch_ip, modulo 2^20; mem_address SHALL be its bits [19:1].
REQ-015: FSM states SHALL be IDLE, FETCH and ABORT.
REQ-016: IDLE -> FETCH SHALL occur when free slots >= 2, or >= 1 when fetch_ip is odd, with mem_access asserted from the next cycle.
REQ-017: In FETCH, mem_access and mem_address SHALL be held stable until mem_ack.
REQ-018: mem_access SHALL be low in the cycle after mem_ack; FSM returns to IDLE.
REQ-019: On mem_ack in FETCH with even fetch_ip:
- mem_data[7:0] SHALL be written, then mem_data[15:8].
- fetch_ip += 2.
REQ-020: On mem_ack in FETCH with odd fetch_ip:
- only mem_data[15:8] SHALL be written.
- fetch_ip += 1.
REQ-021: fetch_ip SHALL wrap modulo 2^16 (0xFFFF + 1 = 0x0000); cs is not modified.
REQ-022: The queue SHALL accept up to 2 written bytes and 1 popped byte in the same cycle; occupancy = old + written - popped.
REQ-023: fifo_rd_en while fifo_empty is high SHALL be ignored, with no pointer or count change.
REQ-024: Read and write pointers SHALL wrap at QUEUE_DEPTH; the queue SHALL never be overfilled (guaranteed by REQ-016).
REQ-025: fifo_rd_data SHALL be the byte at the read pointer, combinational from queue storage.
REQ-026: load_new_ip SHALL, in the next cycle:
- make the queue empty, discarding any same-cycle pop or write;
- load cs = new_cs and fetch_ip = new_ip.
REQ-027: load_new_ip while in FETCH without mem_ack SHALL move the FSM to ABORT; mem_access and mem_address stay unchanged.
REQ-028: In ABORT, mem_ack SHALL discard mem_data; the FSM returns to IDLE and fetching resumes from the new point per REQ-016.
REQ-029: load_new_ip coincident with mem_ack in FETCH SHALL discard mem_data and enter IDLE.
REQ-030: load_new_ip in ABORT SHALL reload cs/ip again and remain in ABORT.
REQ-031: Repeated load_new_ip on consecutive cycles SHALL each take effect; the last one wins.

Reset
REQ-032: While reset_n is low at a clock edge, the block SHALL set:
- FSM = IDLE, mem_access = 0, queue empty, fifo_empty = 1;
- cs = 0xFFFF, fetch_ip = 0x0000.
REQ-033: Reset SHALL override load_new_ip and mem_ack.
REQ-034: A reset during FETCH SHALL drop mem_access with no ABORT; the system resets memory together with this block.
REQ-035: After reset release, the first request SHALL be mem_address = 0xFFFF0 >> 1 = 0x7FFF8.

Verification
REQ-036: Reset release, mem_ack with data 0x1234 -> fifo_rd_data 0x34 then 0x12; fetch_ip = 0x0002; next request at word 0x7FFF9.
REQ-037: load_new_ip cs=0x0000 ip=0x0101, ack with data 0xAB00 -> single byte 0xAB queued; next request at address 0x00102, mem_address 0x00081.
REQ-038: No pops, acks always immediate -> the queue fills to exactly 6 bytes; mem_access stays low until a pop frees 2 slots.
REQ-039: load_new_ip mid-FETCH, ack 2 cycles later with 0xDEAD -> no byte queued, fifo_empty held 1; next request uses the new cs:ip.
REQ-040: cs=0x0000 ip=0xFFFF, ack 0x5500 -> byte 0x55 queued; fetch_ip = 0x0000; next request at linear address 0x00000.
REQ-041: Simultaneous pop and 2-byte write at occupancy 4 -> occupancy 5; byte order preserved across the pointer wrap.
